ahbslv_wbmas_bridge: RTL and testbench

//  AHB-Lite/AHB2 slave to WISHBONE master bridge. It is the companion of the
//  AHB-master/WB-slave bridges on the OR1200 I/D ports. It lets AHB masters
//  (the OR1200 bridges, DMA) reach existing WB peripherals. Each AHB beat

---
 rtl/ahbslv_wbmas_bridge_if.sv | 45 ++++
 rtl/ahbslv_wbmas_bridge.sv | 169 ++++++++++++++++
 tb/tb_ahbslv_wbmas_bridge.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbslv_wbmas_bridge_if.sv
// AHB slave / WISHBONE master signal bundle for ahbslv_wbmas_bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system.
interface ahbslv_wbmas_bridge_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    // AHB side
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hready_in;
    logic          hready_out;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;

    // WISHBONE side
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        output hready_out, hresp, hrdata,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        input  hready_out, hresp, hrdata,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/ahbslv_wbmas_bridge.sv
// AHB-Lite slave to WISHBONE classic master bridge: every AHB beat becomes one WB single cycle.
// Optional macro AHBSLV_WBMAS_WB_ERR_EN: honour wb_err_i and report timeouts as a two-cycle AHB ERROR.
module ahbslv_wbmas_bridge #(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    ahbslv_wbmas_bridge_if.slave        bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = 8;

    localparam logic [1:0]    HRESP_OKAY  = 2'b00;
`ifdef AHBSLV_WBMAS_WB_ERR_EN
    localparam logic [1:0]    HRESP_ERROR = 2'b01;
`endif
    localparam logic [CW-1:0] TO_LIMIT    = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WB,
        S_RESP
`ifdef AHBSLV_WBMAS_WB_ERR_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc_c;
    logic          accept_c;
    logic          unused_c;

    logic          hready_out;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;

    // Byte-lane selects from size and low address bits; big-endian puts byte 0 on lane 3.
    function automatic logic [SW-1:0] byte_sel(input logic [2:0] size, input logic [1:0] a);
        logic [SW-1:0] be;
        be = 4'b1111;
        if (size == 3'b000) begin
            be = 4'b1000 >> a;
        end else if (size == 3'b001) begin
            be = a[1] ? 4'b0011 : 4'b1100;
        end
        if (!BIG_ENDIAN) begin
            be = {be[0], be[1], be[2], be[3]};
        end
        return be;
    endfunction

    assign accept_c  = bus.hsel & bus.hready_in & bus.htrans[1] & hready_out;
    assign cnt_inc_c = cnt + CW'(1);

`ifdef AHBSLV_WBMAS_WB_ERR_EN
    assign unused_c = ^{bus.hburst, bus.htrans[0]};
`else
    assign unused_c = ^{bus.hburst, bus.htrans[0], bus.wb_err_i};
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
            hrdata     <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
        end else begin
            case (state)
                S_DATA: begin
                    wb_dat_o <= bus.hwdata;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    state    <= S_WB;
                end

                S_WB: begin
                    if (bus.wb_ack_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        if (!wb_we_o) begin
                            hrdata <= bus.wb_dat_i;
                        end
                        hready_out <= 1'b1;
                        hresp      <= HRESP_OKAY;
                        state      <= S_RESP;
`ifdef AHBSLV_WBMAS_WB_ERR_EN
                    end else if (bus.wb_err_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        hresp      <= HRESP_ERROR;
                        state      <= S_ERR1;
`endif
                    end else if (cnt_inc_c == TO_LIMIT) begin
                        // Slave never answered: abandon the cycle, reads return zero.
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        if (!wb_we_o) begin
                            hrdata <= '0;
                        end
`ifdef AHBSLV_WBMAS_WB_ERR_EN
                        hresp      <= HRESP_ERROR;
                        state      <= S_ERR1;
`else
                        hready_out <= 1'b1;
                        hresp      <= HRESP_OKAY;
                        state      <= S_RESP;
`endif
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end

`ifdef AHBSLV_WBMAS_WB_ERR_EN
                S_ERR1: begin
                    hready_out <= 1'b1;
                    state      <= S_ERR2;
                end
`endif

                // IDLE, RESP and ERR2 all expose hready_out=1 and may accept a new beat.
                default: begin
                    if (accept_c) begin
                        wb_adr_o   <= {bus.haddr[AW-1:2], 2'b00};
                        wb_we_o    <= bus.hwrite;
                        wb_sel_o   <= byte_sel(bus.hsize, bus.haddr[1:0]);
                        cnt        <= '0;
                        hready_out <= 1'b0;
                        hresp      <= HRESP_OKAY;
                        state      <= S_DATA;
                    end else begin
                        hready_out <= 1'b1;
                        hresp      <= HRESP_OKAY;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.hready_out = hready_out;
    assign bus.hresp      = hresp;
    assign bus.hrdata     = hrdata;
    assign bus.wb_adr_o   = wb_adr_o;
    assign bus.wb_dat_o   = wb_dat_o;
    assign bus.wb_sel_o   = wb_sel_o;
    assign bus.wb_we_o    = wb_we_o;
    assign bus.wb_cyc_o   = wb_cyc_o;
    assign bus.wb_stb_o   = wb_stb_o;
endmodule

// File: tb/tb_ahbslv_wbmas_bridge.sv
// Self-checking bench for ahbslv_wbmas_bridge: directed scenarios plus random beats vs a transaction model.
// Expectations follow AHBSLV_WBMAS_WB_ERR_EN when the bench is built with it.
module tb_ahbslv_wbmas_bridge;
    localparam int unsigned TIMEOUT = 4;

    logic hclk;
    logic hresetn;
    int   checks;
    int   errors;
    logic [31:0] last_rdata;

    ahbslv_wbmas_bridge_if bus ();

    ahbslv_wbmas_bridge #(
        .BIG_ENDIAN (1'b1),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Expected lane enables, big-endian: byte at offset k lands on lane 3-k.
    function automatic logic [3:0] exp_sel(input logic [2:0] size, input logic [1:0] a);
        if (size == 3'd0) return 4'(1 << (3 - int'(a)));
        if (size == 3'd1) return (a[1] == 1'b0) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // One AHB beat, entered and left at a negedge where hready_out must be 1.
    // ack_at/err_at: WB cycle (1-based) in which the slave asserts ack/err, 0 = never.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] sdata,
                        input int ack_at, input int err_at, input string tag);
        int          term;
        int          kind;
        logic        err_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  sel;
        logic [31:0] adr;

        term = TIMEOUT;
        kind = 2;
        if (ack_at >= 1 && ack_at <= int'(TIMEOUT)) begin
            term = ack_at;
            kind = 0;
        end
`ifdef AHBSLV_WBMAS_WB_ERR_EN
        if (err_at >= 1 && (err_at < term || (err_at == term && kind == 2))) begin
            term = err_at;
            kind = 1;
        end
        err_resp = (kind != 0);
`else
        err_resp = 1'b0;
`endif
        exp_rdata = last_rdata;
        if (!wr) begin
            if (kind == 0) exp_rdata = sdata;
            else if (kind == 2) exp_rdata = 32'h0;
        end
        sel = exp_sel(size, addr[1:0]);
        adr = addr & 32'hFFFF_FFFC;

        checks++;
        if (bus.hready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s addr_phase hready_out got %b want 1", tag, bus.hready_out);
        end
        bus.hsel      = 1'b1;
        bus.haddr     = addr;
        bus.htrans    = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        bus.hwrite    = wr;
        bus.hsize     = size;
        bus.hburst    = 3'($urandom);
        bus.hready_in = 1'b1;
        bus.hwdata    = $urandom;
        @(negedge hclk);

        checks++;
        if ({bus.hready_out, bus.wb_cyc_o, bus.wb_stb_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s data_phase {hready,cyc,stb} got %b want 000", tag,
                     {bus.hready_out, bus.wb_cyc_o, bus.wb_stb_o});
        end
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.haddr  = $urandom;
        bus.hwdata = wdata;
        @(negedge hclk);
        bus.hwdata = $urandom;

        for (int n = 1; n <= term; n++) begin
            checks++;
            if ({bus.hready_out, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o}
                !== {1'b0, 1'b1, 1'b1, wr, sel, adr}) begin
                errors++;
                $display("FAIL %s wb_cycle%0d {hrdy,cyc,stb,we,sel,adr} got %b_%b_%b_%b_%b_%h want %b_%b_%b_%b_%b_%h",
                         tag, n, bus.hready_out, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
                         bus.wb_adr_o, 1'b0, 1'b1, 1'b1, wr, sel, adr);
            end
            if (wr) begin
                checks++;
                if (bus.wb_dat_o !== wdata) begin
                    errors++;
                    $display("FAIL %s wb_dat_o got %h want %h", tag, bus.wb_dat_o, wdata);
                end
            end
            bus.wb_ack_i = (n == ack_at);
            bus.wb_err_i = (n == err_at);
            bus.wb_dat_i = (n == ack_at) ? sdata : $urandom;
            @(negedge hclk);
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = $urandom;

        if (err_resp) begin
            checks++;
            if ({bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o} !== 5'b0_01_00) begin
                errors++;
                $display("FAIL %s err_first {hrdy,hresp,cyc,stb} got %b want 0_01_00", tag,
                         {bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o});
            end
            @(negedge hclk);
        end
        checks++;
        if ({bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o, bus.hrdata}
            !== {1'b1, (err_resp ? 2'b01 : 2'b00), 2'b00, exp_rdata}) begin
            errors++;
            $display("FAIL %s response {hrdy,hresp,cyc,stb} got %b_%b_%b%b hrdata %h want %b_%b_00 hrdata %h",
                     tag, bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o, bus.hrdata,
                     1'b1, (err_resp ? 2'b01 : 2'b00), exp_rdata);
        end
        last_rdata = exp_rdata;
    endtask

    // One cycle of non-accepted bus activity; bridge must stay idle with zero-wait OKAY.
    task automatic gap_cycle(input logic sel, input logic [1:0] tr, input logic rdy, input string tag);
        bus.hsel      = sel;
        bus.htrans    = tr;
        bus.hready_in = rdy;
        bus.haddr     = $urandom;
        bus.hwrite    = 1'($urandom);
        @(negedge hclk);
        checks++;
        if ({bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o} !== 5'b1_00_00) begin
            errors++;
            $display("FAIL %s idle {hrdy,hresp,cyc,stb} got %b want 1_00_00", tag,
                     {bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o});
        end
        bus.hsel      = 1'b0;
        bus.htrans    = 2'b00;
        bus.hready_in = 1'b1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        @(negedge hclk);
        checks++;
        if ({bus.hready_out, bus.hresp, bus.hrdata} !== {1'b1, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_ahb {hrdy,hresp,hrdata} got %b_%b_%h want 1_00_00000000",
                     bus.hready_out, bus.hresp, bus.hrdata);
        end
        checks++;
        if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o} !== 75'h0) begin
            errors++;
            $display("FAIL reset_wb adr %h dat %h sel %b we %b cyc %b stb %b want all zero",
                     bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o);
        end
        hresetn = 1'b1;
        last_rdata = 32'h0;
        gap_cycle(1'b0, 2'b00, 1'b1, "post_reset");
    endtask

    task automatic test_idle_busy();
        gap_cycle(1'b1, 2'b00, 1'b1, "sel_idle");
        gap_cycle(1'b1, 2'b01, 1'b1, "sel_busy");
        gap_cycle(1'b1, 2'b10, 1'b0, "nonseq_hready_in_low");
        gap_cycle(1'b0, 2'b10, 1'b1, "nonseq_unselected");
    endtask

    task automatic test_word_read();
        xfer(32'h0000_0100, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 1, 0, "word_read");
        checks++;
        if (bus.hrdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL word_read_hrdata got %h want 12345678", bus.hrdata);
        end
    endtask

    task automatic test_byte_write();
        xfer(32'h0000_0203, 1'b1, 3'b000, 32'h0000_00AB, $urandom, 1, 0, "byte_write");
        xfer(32'h0000_0202, 1'b1, 3'b001, 32'h0000_BEEF, $urandom, 2, 0, "half_write_hi");
        xfer(32'h0000_0200, 1'b0, 3'b000, 32'h0, 32'hA1B2_C3D4, 3, 0, "byte_read_lane3");
    endtask

    task automatic test_back_to_back();
        xfer(32'h0000_0400, 1'b0, 3'b010, 32'h0, 32'h1111_2222, 1, 0, "b2b_read1");
        xfer(32'h0000_0404, 1'b0, 3'b010, 32'h0, 32'h3333_4444, 1, 0, "b2b_read2");
        xfer(32'h0000_0408, 1'b1, 3'b010, 32'hDEAD_BEEF, $urandom, 2, 0, "b2b_write");
        xfer(32'h0000_040C, 1'b0, 3'b011, 32'h0, 32'h5555_6666, 1, 0, "b2b_read3");
    endtask

    task automatic test_err();
        xfer(32'h0000_0500, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA, 4, 3, "err_3rd_read");
        xfer(32'h0000_0504, 1'b1, 3'b010, 32'h0BAD_0BAD, $urandom, 4, 1, "err_1st_write");
        xfer(32'h0000_0508, 1'b0, 3'b010, 32'h0, 32'h7777_8888, 2, 2, "ack_err_same");
    endtask

    task automatic test_timeout();
        xfer(32'h0000_0600, 1'b0, 3'b010, 32'h0, 32'h9999_0000, 1, 0, "pre_timeout_read");
        xfer(32'h0000_0604, 1'b1, 3'b010, 32'h1357_9BDF, $urandom, 0, 0, "timeout_write");
        xfer(32'h0000_0608, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFFF, 0, 0, "timeout_read");
        xfer(32'h0000_060C, 1'b0, 3'b010, 32'h0, 32'h2468_ACE0, 5, 0, "ack_too_late");
    endtask

    task automatic test_reset_mid();
        bus.hsel      = 1'b1;
        bus.haddr     = 32'h0000_0340;
        bus.htrans    = 2'b10;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'b010;
        bus.hready_in = 1'b1;
        @(negedge hclk);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        @(negedge hclk);
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_pre {cyc,stb} got %b want 11", {bus.wb_cyc_o, bus.wb_stb_o});
        end
        #2 hresetn = 1'b0;
        #1;
        checks++;
        if ({bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o, bus.hrdata} !== {1'b1, 2'b00, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_async {hrdy,hresp,cyc,stb} got %b hrdata %h want 1_00_00 hrdata 0",
                     {bus.hready_out, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o}, bus.hrdata);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        last_rdata = 32'h0;
        gap_cycle(1'b0, 2'b00, 1'b1, "reset_mid_idle");
        xfer(32'h0000_0344, 1'b0, 3'b010, 32'h0, 32'hCAFE_F00D, 2, 0, "post_reset_read");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          ack_at;
        int          err_at;
        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                gap_cycle(1'($urandom), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01, 1'b1, "rand_gap");
            end
            a      = $urandom;
            ack_at = int'($urandom_range(0, 5));
            err_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            xfer(a, 1'($urandom), 3'($urandom_range(0, 4)), $urandom, $urandom, ack_at, err_at, "rand");
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        last_rdata    = 32'h0;
        hresetn       = 1'b0;
        bus.hsel      = 1'b0;
        bus.haddr     = 32'h0;
        bus.htrans    = 2'b00;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'b000;
        bus.hburst    = 3'b000;
        bus.hwdata    = 32'h0;
        bus.hready_in = 1'b1;
        bus.wb_dat_i  = 32'h0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_err_i  = 1'b0;

        test_reset();
        test_idle_busy();
        test_word_read();
        test_byte_write();
        test_back_to_back();
        test_err();
        test_timeout();
        test_reset_mid();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
